// File: rtl/rev_tri_index_sequencer.sv
// Reverse-direction (oc, ic, op) tuple generator that walks an upper-triangular
// matrix bottom-up for back-substitution. One tuple per valid/ready handshake.
module rev_tri_index_sequencer #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 4,
   parameter int unsigned CW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          ready,
   output logic          valid,
   output logic [IW-1:0] oc,
   output logic [IW-1:0] ic,
   output logic          op_div,
   output logic          last,
   output logic [CW-1:0] op_idx,
   output logic          busy,
   output logic          done
);

   localparam logic [IW-1:0] TOP = IW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state, state_n;
   logic            valid_n;
   logic [IW-1:0]   oc_n, ic_n;
   logic            op_div_n;
   logic [CW-1:0]   op_idx_n;
   logic            done_n;

   // Final tuple marker and activity flag, both derived from registered state.
   assign last = valid && (oc == '0) && (ic == '0);
   assign busy = (state == RUN);

   // State and tuple registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         valid  <= 1'b0;
         oc     <= '0;
         ic     <= '0;
         op_div <= 1'b0;
         op_idx <= '0;
         done   <= 1'b0;
      end else begin
         state  <= state_n;
         valid  <= valid_n;
         oc     <= oc_n;
         ic     <= ic_n;
         op_div <= op_div_n;
         op_idx <= op_idx_n;
         done   <= done_n;
      end
   end

   // Next-state and tuple advance; diagonal check comes first so oc+1 cannot wrap into the MAC path.
   always_comb begin
      state_n  = state;
      valid_n  = valid;
      oc_n     = oc;
      ic_n     = ic;
      op_div_n = op_div;
      op_idx_n = op_idx;
      done_n   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_n  = RUN;
               valid_n  = 1'b1;
               oc_n     = TOP;
               ic_n     = TOP;
               op_div_n = 1'b1;
               op_idx_n = '0;
            end
         end
         RUN: begin
            if (valid && ready) begin
               if (last) begin
                  state_n = DONE;
                  valid_n = 1'b0;
                  done_n  = 1'b1;
               end else if (ic == oc) begin
                  op_idx_n = op_idx + CW'(1);
                  oc_n     = oc - IW'(1);
                  ic_n     = TOP;
                  op_div_n = ((oc - IW'(1)) == TOP);
               end else if (ic == (oc + IW'(1))) begin
                  op_idx_n = op_idx + CW'(1);
                  ic_n     = oc;
                  op_div_n = 1'b1;
               end else begin
                  op_idx_n = op_idx + CW'(1);
                  ic_n     = ic - IW'(1);
                  op_div_n = 1'b0;
               end
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
            valid_n = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_rev_tri_index_sequencer.sv
// Directed bench for rev_tri_index_sequencer: N=4 sweeps plus N=1 and N=2 builds.
module tb_rev_tri_index_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, start, ready;
   logic       valid, op_div, last, busy, done;
   logic [3:0] oc, ic, op_idx;

   logic       start1, ready1;
   logic       valid1, op_div1, last1, busy1, done1;
   logic [3:0] oc1, ic1, op_idx1;

   logic       start2, ready2;
   logic       valid2, op_div2, last2, busy2, done2;
   logic [3:0] oc2, ic2, op_idx2;

   int checks   = 0;
   int failures = 0;

   int exp_oc  [10] = '{3, 2, 2, 1, 1, 1, 0, 0, 0, 0};
   int exp_ic  [10] = '{3, 3, 2, 3, 2, 1, 3, 2, 1, 0};
   int exp_div [10] = '{1, 0, 1, 0, 0, 1, 0, 0, 0, 1};

   rev_tri_index_sequencer #(.N(4), .IW(4), .CW(4)) dut (
      .clk(clk), .reset(reset), .start(start), .ready(ready),
      .valid(valid), .oc(oc), .ic(ic), .op_div(op_div), .last(last),
      .op_idx(op_idx), .busy(busy), .done(done)
   );

   rev_tri_index_sequencer #(.N(1), .IW(4), .CW(4)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .ready(ready1),
      .valid(valid1), .oc(oc1), .ic(ic1), .op_div(op_div1), .last(last1),
      .op_idx(op_idx1), .busy(busy1), .done(done1)
   );

   rev_tri_index_sequencer #(.N(2), .IW(4), .CW(4)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .ready(ready2),
      .valid(valid2), .oc(oc2), .ic(ic2), .op_div(op_div2), .last(last2),
      .op_idx(op_idx2), .busy(busy2), .done(done2)
   );

   // Advance one clock and settle past the edge.
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [16:0] got;
      reset = 1'b1; start = 1'b0; ready = 1'b0;
      start1 = 1'b0; ready1 = 1'b0; start2 = 1'b0; ready2 = 1'b0;
      step; step;
      reset = 1'b0;
      got = {valid, oc, ic, op_div, last, op_idx, busy, done};
      checks++;
      if (got !== 17'h0) begin
         failures++;
         $display("FAIL reset_n4 got=%h exp=00000", got);
      end
      got = {valid1, oc1, ic1, op_div1, last1, op_idx1, busy1, done1};
      checks++;
      if (got !== 17'h0) begin
         failures++;
         $display("FAIL reset_n1 got=%h exp=00000", got);
      end
      got = {valid2, oc2, ic2, op_div2, last2, op_idx2, busy2, done2};
      checks++;
      if (got !== 17'h0) begin
         failures++;
         $display("FAIL reset_n2 got=%h exp=00000", got);
      end
   endtask

   // mode 0: ready=1, 1: 3-cycle stall at op_idx 4, 2: random ready, 3: start pulses in RUN and DONE
   task automatic run_sweep4(input int mode, input string tag);
      int k, cyc, stall, macs, divs;
      logic r;
      logic [16:0] got, exp;
      k = 0; cyc = 0; stall = 0; macs = 0; divs = 0;
      start = 1'b1; ready = 1'b1;
      step;
      start = 1'b0;
      while (k < 10 && cyc < 200) begin
         got = {valid, oc, ic, op_div, last, op_idx, busy, done};
         exp = {1'b1, 4'(exp_oc[k]), 4'(exp_ic[k]), 1'(exp_div[k]), (k == 9), 4'(k), 1'b1, 1'b0};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL %s tuple%0d cyc%0d got v=%b oc=%0d ic=%0d div=%b last=%b idx=%0d busy=%b done=%b exp=%h got=%h",
                     tag, k, cyc, valid, oc, ic, op_div, last, op_idx, busy, done, exp, got);
         end
         case (mode)
            1:       r = !(k == 4 && stall < 3);
            2:       r = 1'($urandom_range(0, 1));
            default: r = 1'b1;
         endcase
         if (mode == 1 && k == 4 && !r) stall++;
         start = (mode == 3) && (k == 3 || k == 7);
         ready = r;
         if (r) begin
            if (op_div) divs++;
            else        macs++;
         end
         step;
         cyc++;
         if (r) k++;
      end
      start = 1'b0;
      checks++;
      if (k != 10) begin
         failures++;
         $display("FAIL %s_timeout got=%0d tuples exp=10", tag, k);
      end
      got = {valid, busy, done, last, 13'h0};
      checks++;
      if (got !== {1'b0, 1'b0, 1'b1, 1'b0, 13'h0}) begin
         failures++;
         $display("FAIL %s_done got v=%b busy=%b done=%b last=%b exp v=0 busy=0 done=1 last=0",
                  tag, valid, busy, done, last);
      end
      checks++;
      if (macs != 6 || divs != 4) begin
         failures++;
         $display("FAIL %s_opcount got mac=%0d div=%0d exp mac=6 div=4", tag, macs, divs);
      end
      if (mode == 3) start = 1'b1;
      step;
      start = 1'b0;
      checks++;
      if ({valid, busy, done} !== 3'b000) begin
         failures++;
         $display("FAIL %s_done_pulse got v=%b busy=%b done=%b exp 000", tag, valid, busy, done);
      end
      step;
      checks++;
      if ({valid, busy, done} !== 3'b000) begin
         failures++;
         $display("FAIL %s_idle got v=%b busy=%b done=%b exp 000", tag, valid, busy, done);
      end
      ready = 1'b0;
   endtask

   task automatic test_full_sweep;
      run_sweep4(0, "full");
   endtask

   task automatic test_backpressure;
      run_sweep4(1, "stall");
   endtask

   task automatic test_back_to_back;
      run_sweep4(3, "b2b_a");
      run_sweep4(0, "b2b_b");
   endtask

   task automatic test_random_ready;
      run_sweep4(2, "rand");
   endtask

   task automatic test_reset_mid;
      start = 1'b1; ready = 1'b1;
      step;
      start = 1'b0;
      repeat (6) step;
      checks++;
      if (op_idx !== 4'd6 || valid !== 1'b1) begin
         failures++;
         $display("FAIL midrst_pre got idx=%0d v=%b exp idx=6 v=1", op_idx, valid);
      end
      reset = 1'b1;
      step;
      reset = 1'b0; ready = 1'b0;
      checks++;
      if ({valid, busy, done, op_idx} !== 7'h0) begin
         failures++;
         $display("FAIL midrst got v=%b busy=%b done=%b idx=%0d exp all 0", valid, busy, done, op_idx);
      end
      step;
      checks++;
      if ({valid, busy, done} !== 3'b000) begin
         failures++;
         $display("FAIL midrst_nodone got v=%b busy=%b done=%b exp 000", valid, busy, done);
      end
      run_sweep4(0, "replay");
   endtask

   task automatic test_n1;
      logic [11:0] got;
      start1 = 1'b1; ready1 = 1'b1;
      step;
      start1 = 1'b0;
      got = {valid1, oc1, ic1, op_div1, last1, busy1};
      checks++;
      if (got !== {1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1} || op_idx1 !== 4'd0) begin
         failures++;
         $display("FAIL n1_tuple got=%h idx=%0d exp=%h idx=0", got, op_idx1,
                  {1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1});
      end
      step;
      checks++;
      if ({valid1, busy1, done1} !== 3'b001) begin
         failures++;
         $display("FAIL n1_done got v=%b busy=%b done=%b exp 001", valid1, busy1, done1);
      end
      step;
      ready1 = 1'b0;
      checks++;
      if ({valid1, busy1, done1} !== 3'b000) begin
         failures++;
         $display("FAIL n1_idle got v=%b busy=%b done=%b exp 000", valid1, busy1, done1);
      end
   endtask

   task automatic test_n2;
      int e_oc [3] = '{1, 0, 0};
      int e_ic [3] = '{1, 1, 0};
      int e_dv [3] = '{1, 0, 1};
      logic [15:0] got, exp;
      start2 = 1'b1; ready2 = 1'b1;
      step;
      start2 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         got = {valid2, oc2, ic2, op_div2, last2, op_idx2, busy2};
         exp = {1'b1, 4'(e_oc[k]), 4'(e_ic[k]), 1'(e_dv[k]), (k == 2), 4'(k), 1'b1};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL n2_tuple%0d got=%h exp=%h", k, got, exp);
         end
         step;
      end
      ready2 = 1'b0;
      checks++;
      if ({valid2, busy2, done2} !== 3'b001) begin
         failures++;
         $display("FAIL n2_done got v=%b busy=%b done=%b exp 001", valid2, busy2, done2);
      end
   endtask

   initial begin
      test_reset;
      test_full_sweep;
      test_backpressure;
      test_back_to_back;
      test_reset_mid;
      test_random_ready;
      test_n1;
      test_n2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
